instr_fetch: RTL and testbench

Instruction fetch stage placed directly upstream of the instruction ROM and downstream decode. The block:
- owns the program counter and drives the ROM word address;
- captures the returned instruction word into a 2-entry buffer;
- presents `{pc, instr, pc+4}` to decode through a valid/ready handshake.

Branch/jump redirects flush buffered entries. Misaligned or out-of-range fetch targets raise a sticky fault instead of issuing a fetch.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          FETCH_DEPTH = 2;
    localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;

    // One buffered fetch: the byte address and the word the ROM returned for it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetch entries; head is presented combinationally.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam logic [1:0] DEPTH_C = 2'(FETCH_DEPTH);

    fetch_entry_t mem [FETCH_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == 2'd0);
    assign do_pop  = pop && !empty && !flush;
    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop) && !flush;
    assign head    = mem[rd_ptr];

    // Storage write; when full with a simultaneous pop, the slot being written is the one leaving.
    // NOTE: the storage array has no reset; every consumer gates it with the valid count, so its
    // power-up contents are never observed and leaving it unreset keeps it a plain register file.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; 1-bit pointers wrap naturally modulo 2.
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, checks fetch targets, buffers ROM words for decode.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        out_fault
);

    localparam logic [31:0] ROM_LIMIT = 32'(ROM_DEPTH);

    fetch_state_e state;
    logic [31:0]  pc;
    logic         fault_q;
    logic         pop;
    logic         want_fetch;
    logic         pc_in_range;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t fifo_din;
    fetch_entry_t fifo_head;

    assign instr_addr  = pc;
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;
    // A slot is available if the buffer is not full or the head is leaving this cycle.
    assign want_fetch  = (state == RUN) && (!fifo_full || pop);
    assign pc_in_range = (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < ROM_LIMIT);
    // Redirect wins over any same-cycle push or pop; the flush discards both.
    assign fifo_push   = want_fetch && pc_in_range && !redirect_valid;
    assign fifo_pop    = pop && !redirect_valid;
    assign fifo_din    = '{pc: pc, instr: instr_data};

    fetch_fifo u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .flush   (redirect_valid),
        .din     (fifo_din),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Head fields read as zero whenever no entry is valid, including right after reset.
    assign out_instr    = out_valid ? fifo_head.instr       : 32'd0;
    assign out_pc       = out_valid ? fifo_head.pc          : 32'd0;
    assign out_pc_plus4 = out_valid ? fifo_head.pc + 32'd4  : 32'd0;
    assign out_fault    = fault_q;

    // PC sequencing and the RUN/FAULT machine; a bad target parks the stage until redirected.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_PC;
            state   <= RUN;
            fault_q <= 1'b0;
        end else if (redirect_valid) begin
            pc      <= redirect_pc;
            state   <= RUN;
            fault_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (want_fetch) begin
                        if (pc_in_range) begin
                            pc <= pc + 32'd4;
                        end else begin
                            state   <= FAULT;
                            fault_q <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    pc <= pc;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirect, fault, reset.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;

    logic [31:0] instr_addr, instr_data;
    logic        out_valid, out_fault;
    logic [31:0] out_instr, out_pc, out_pc_plus4;

    logic [31:0] s_addr, s_data;
    logic        s_valid, s_fault;
    logic [31:0] s_instr, s_pc, s_pc_plus4;

    logic [31:0] rom [64];

    int total = 0;
    int bad   = 0;

    instr_fetch #(.RESET_PC(32'h0), .ROM_DEPTH(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .out_fault(out_fault)
    );

    instr_fetch #(.RESET_PC(32'h0), .ROM_DEPTH(4)) dut_small (
        .clk(clk), .reset_n(reset_n),
        .instr_addr(s_addr), .instr_data(s_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(s_valid), .out_ready(out_ready),
        .out_instr(s_instr), .out_pc(s_pc), .out_pc_plus4(s_pc_plus4),
        .out_fault(s_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM word i holds 0xA000_0000 + i; out-of-range reads return the filler NOP.
    always_comb begin
        instr_data = INSTR_NOP;
        s_data     = INSTR_NOP;
        if (instr_addr[31:8] == 24'd0) instr_data = rom[instr_addr[7:2]];
        if (s_addr[31:8] == 24'd0)     s_data     = rom[s_addr[7:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset over two edges, release just after an edge: the next edge fetches RESET_PC.
    task automatic do_reset(input logic ready);
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = ready;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (out_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", out_fault); end
        total++; if (instr_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", instr_addr); end
        total++; if (out_pc !== 32'h0 || out_instr !== 32'h0 || out_pc_plus4 !== 32'h0) begin
            bad++; $display("FAIL reset_outs pc=%h instr=%h plus4=%h exp all 0", out_pc, out_instr, out_pc_plus4);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        logic [31:0] exp_in [4] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002, 32'hA000_0003};
        logic [31:0] exp_p4 [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (out_valid !== 1'b1 || out_pc !== exp_pc[k]) begin
                bad++; $display("FAIL stream_pc[%0d] valid=%b pc=%h exp valid=1 pc=%h", k, out_valid, out_pc, exp_pc[k]);
            end
            total++; if (out_instr !== exp_in[k]) begin
                bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", k, out_instr, exp_in[k]);
            end
            total++; if (out_pc_plus4 !== exp_p4[k]) begin
                bad++; $display("FAIL stream_plus4[%0d] got=%h exp=%h", k, out_pc_plus4, exp_p4[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc [3] = '{32'h0, 32'h4, 32'h8};
        do_reset(1'b0);
        repeat (5) step();
        total++; if (instr_addr !== 32'h8) begin bad++; $display("FAIL bp_addr got=%h exp=8", instr_addr); end
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== 32'hA000_0000) begin
            bad++; $display("FAIL bp_head valid=%b pc=%h instr=%h exp 1/0/a0000000", out_valid, out_pc, out_instr);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++; if (out_valid !== 1'b1 || out_pc !== exp_pc[k]) begin
                bad++; $display("FAIL bp_drain[%0d] valid=%b pc=%h exp valid=1 pc=%h", k, out_valid, out_pc, exp_pc[k]);
            end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b1);
        step();
        step();
        total++; if (out_pc !== 32'h4) begin bad++; $display("FAIL redir_pre got=%h exp=4", out_pc); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1C;
        step();
        redirect_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%b exp=0", out_valid); end
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h1C || out_instr !== 32'hA000_0007) begin
            bad++; $display("FAIL redir_target valid=%b pc=%h instr=%h exp 1/1c/a0000007", out_valid, out_pc, out_instr);
        end
        step();
        total++; if (out_pc !== 32'h20) begin bad++; $display("FAIL redir_next got=%h exp=20", out_pc); end
    endtask

    task automatic test_fault();
        do_reset(1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1E;
        step();
        redirect_valid = 1'b0;
        total++; if (out_fault !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL fault_early fault=%b valid=%b exp 0/0", out_fault, out_valid);
        end
        step();
        total++; if (out_fault !== 1'b1) begin bad++; $display("FAIL fault_set got=%b exp=1", out_fault); end
        repeat (2) step();
        total++; if (instr_addr !== 32'h1E || out_valid !== 1'b0 || out_fault !== 1'b1) begin
            bad++; $display("FAIL fault_hold addr=%h valid=%b fault=%b exp 1e/0/1", instr_addr, out_valid, out_fault);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        redirect_valid = 1'b0;
        total++; if (out_fault !== 1'b0) begin bad++; $display("FAIL fault_clear got=%b exp=0", out_fault); end
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'hA000_0008) begin
            bad++; $display("FAIL fault_recover valid=%b pc=%h instr=%h exp 1/20/a0000008", out_valid, out_pc, out_instr);
        end
    endtask

    task automatic test_small_rom();
        logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        do_reset(1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (s_valid !== 1'b1 || s_pc !== exp_pc[k] || s_fault !== 1'b0) begin
                bad++; $display("FAIL small_entry[%0d] valid=%b pc=%h fault=%b exp 1/%h/0", k, s_valid, s_pc, s_fault, exp_pc[k]);
            end
        end
        step();
        total++; if (s_fault !== 1'b1 || s_valid !== 1'b0) begin
            bad++; $display("FAIL small_fault fault=%b valid=%b exp 1/0", s_fault, s_valid);
        end
        repeat (2) step();
        total++; if (s_addr !== 32'h10) begin bad++; $display("FAIL small_addr got=%h exp=10", s_addr); end
    endtask

    task automatic test_async_reset();
        do_reset(1'b0);
        repeat (3) step();
        total++; if (out_valid !== 1'b1 || instr_addr !== 32'h8) begin
            bad++; $display("FAIL areset_pre valid=%b addr=%h exp 1/8", out_valid, instr_addr);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || instr_addr !== 32'h0 || out_pc !== 32'h0) begin
            bad++; $display("FAIL areset_now valid=%b addr=%h pc=%h exp 0/0/0", out_valid, instr_addr, out_pc);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        step();
        total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            bad++; $display("FAIL areset_restart0 valid=%b pc=%h exp 1/0", out_valid, out_pc);
        end
        step();
        total++; if (out_pc !== 32'h4) begin bad++; $display("FAIL areset_restart1 got=%h exp=4", out_pc); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + 32'(i);
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        out_ready      = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_fault();
        test_small_rom();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
